// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the MIPS clock-enable sequencer.
// Optional breakpoint support is enabled by defining CPU_STEP_CTRL_BREAKPOINT_EN.
package cpu_step_ctrl_pkg;

    // Mode encodings, also shown on the character display.
    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    // 10 ms of button stability at 100 MHz.
    localparam int DB_CYCLES_DEFAULT = 1000000;

    // Width of the core program counter compared against the breakpoint.
    localparam int PC_W = 32;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board-side control and status bundle of the clock-enable sequencer.
// Breakpoint signals exist only when CPU_STEP_CTRL_BREAKPOINT_EN is defined.
interface cpu_step_ctrl_if #(
    parameter int DIV_W = 24,
    parameter int CNT_W = 32
);
    import cpu_step_ctrl_pkg::*;

    logic             run_sw;
    logic             step_btn;
    logic [DIV_W-1:0] div_val;
    logic             cpu_ce;
    logic             cpu_phase;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       state;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    logic [PC_W-1:0]  cpu_pc;
    logic [PC_W-1:0]  bp_addr;
    logic             bp_valid;
    logic             bp_hit;

    modport master (
        output run_sw, step_btn, div_val, cpu_pc, bp_addr, bp_valid,
        input  cpu_ce, cpu_phase, cycle_cnt, state, bp_hit
    );

    modport slave (
        input  run_sw, step_btn, div_val, cpu_pc, bp_addr, bp_valid,
        output cpu_ce, cpu_phase, cycle_cnt, state, bp_hit
    );
`else
    modport master (
        output run_sw, step_btn, div_val,
        input  cpu_ce, cpu_phase, cycle_cnt, state
    );

    modport slave (
        input  run_sw, step_btn, div_val,
        output cpu_ce, cpu_phase, cycle_cnt, state
    );
`endif

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes an asynchronous board button, debounces it and emits a
// one-clock pulse on each accepted press. Reusable for any board button.
module btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          rise_q, rise_d;

    // Next-state: two-flop sync, stability counter that restarts on any
    // bounce, and a registered rising-edge detector on the accepted level.
    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        cnt_d       = '0;
        level_d     = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        level_dly_d = level_q;
        rise_d      = level_q & ~level_dly_q;
    end

    // State registers, all cleared by reset so no press is seen at start-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for the MIPS core: halted, free-run at a
// programmable period, or single-step from a debounced button.
// Define CPU_STEP_CTRL_BREAKPOINT_EN to add a PC breakpoint that halts RUN.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DIV_W     = 24,
    parameter int CNT_W     = 32,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_step_ctrl_if.slave bus
);

    logic             run_meta_q, run_meta_d;
    logic             run_s_q, run_s_d;
    logic             step_level;
    logic             step_req;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    logic             bp_hit_q, bp_hit_d;
    logic             bp_match;
`endif

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (bus.step_btn),
        .level  (step_level),
        .rise   (step_req)
    );

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    assign bp_match = bus.bp_valid && (bus.cpu_pc == bus.bp_addr);
`endif

    // Next-state: mode transitions, run-rate divider and the enable pulse.
    // Phase and pulse count follow the pulse on the same edge it is issued.
    always_comb begin
        run_meta_d = bus.run_sw;
        run_s_d    = run_meta_q;
        state_d    = state_q;
        div_d      = div_q;
        ce_d       = 1'b0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        bp_hit_d   = bp_hit_q;
`endif
        case (state_q)
            HALT: begin
                if (run_s_q) begin
                    state_d = RUN;
                    div_d   = '0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end else if (step_req) begin
                    state_d = STEP;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
            end
            STEP: begin
                ce_d    = 1'b1;
                state_d = HALT;
            end
            RUN: begin
                if (!run_s_q) begin
                    state_d = HALT;
                    div_d   = '0;
                end else if (div_q >= bus.div_val) begin
                    div_d = '0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
                    if (bp_match) begin
                        state_d  = HALT;
                        bp_hit_d = 1'b1;
                    end else begin
                        ce_d = 1'b1;
                    end
`else
                    ce_d = 1'b1;
`endif
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = HALT;
                div_d   = '0;
            end
        endcase
        phase_d = phase_q ^ ce_d;
        cnt_d   = cnt_q + CNT_W'(ce_d);
    end

    // All controller state; reset aborts any run or step in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            state_q    <= HALT;
            div_q      <= '0;
            ce_q       <= 1'b0;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
            bp_hit_q   <= 1'b0;
`endif
        end else begin
            run_meta_q <= run_meta_d;
            run_s_q    <= run_s_d;
            state_q    <= state_d;
            div_q      <= div_d;
            ce_q       <= ce_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
            bp_hit_q   <= bp_hit_d;
`endif
        end
    end

    assign bus.cpu_ce    = ce_q;
    assign bus.cpu_phase = phase_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.state     = state_q;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    assign bus.bp_hit    = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: stimulus pushes the expected cycle,
// count and phase of every enable pulse; a monitor checks each pulse seen.
module tb_cpu_step_ctrl;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;
    localparam int DB    = 4;

    typedef struct {
        int               at_cyc;
        logic [CNT_W-1:0] cnt;
        logic             phase;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   pulse_n;
    int   c;
    exp_t exp_q[$];

    cpu_step_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    cpu_step_ctrl #(
        .DIV_W     (DIV_W),
        .CNT_W     (CNT_W),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time expected pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectPulse(input int at_cyc);
        exp_t e;
        pulse_n++;
        e.at_cyc = at_cyc;
        e.cnt    = CNT_W'(pulse_n);
        e.phase  = pulse_n[0];
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic run, input logic btn, input logic [DIV_W-1:0] div);
        bus.run_sw   = run;
        bus.step_btn = btn;
        bus.div_val  = div;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every enable pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.cpu_ce) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ce_cycle", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("ce_cycle", 32'(cyc), 32'(e.at_cyc));
                checkOutput("ce_cycle_cnt", 32'(bus.cycle_cnt), 32'(e.cnt));
                checkOutput("ce_phase", 32'(bus.cpu_phase), 32'(e.phase));
            end
        end
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        pulse_n  = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        bus.cpu_pc   = '0;
        bus.bp_addr  = '0;
        bus.bp_valid = 1'b0;
`endif
        waitCycles(3);
        checkOutput("reset_ce", 32'(bus.cpu_ce), 0);
        checkOutput("reset_phase", 32'(bus.cpu_phase), 0);
        checkOutput("reset_cnt", 32'(bus.cycle_cnt), 0);
        checkOutput("reset_state", 32'(bus.state), 0);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        checkOutput("reset_bp_hit", 32'(bus.bp_hit), 0);
`endif
        rst_n = 1'b1;

        // Idle: no requests, no pulses.
        waitCycles(100);
        checkOutput("idle_state", 32'(bus.state), 0);
        checkOutput("idle_cnt", 32'(bus.cycle_cnt), 0);

        // Single step with a 2-clock bounce; pulse 9 clocks after final rise.
        bus.step_btn = 1'b1;
        waitCycles(1);
        bus.step_btn = 1'b0;
        waitCycles(1);
        bus.step_btn = 1'b1;
        c = cyc;
        expectPulse(c + 9);
        waitCycles(8);
        checkOutput("step_state_step", 32'(bus.state), 2);
        waitCycles(2);
        checkOutput("step_state_halt", 32'(bus.state), 0);
        checkOutput("step_cnt", 32'(bus.cycle_cnt), 1);
        checkOutput("step_phase", 32'(bus.cpu_phase), 1);
        waitCycles(10);
        bus.step_btn = 1'b0;
        waitCycles(12);

        // Free run: period 4, ignored step press, period 1, back to 4,
        // then run_sw dropped just before a pulse would be due.
        c = cyc;
        applyStimulus(1'b1, 1'b0, 8'd3);
        for (int k = 0; k < 10; k++) expectPulse(c + 7 + 4 * k);
        for (int k = 0; k < 4; k++) expectPulse(c + 45 + k);
        expectPulse(c + 52);
        for (int k = 1; k <= 76; k++) begin
            @(negedge clk);
            case (k)
                10: bus.step_btn = 1'b1;
                20: bus.step_btn = 1'b0;
                44: bus.div_val = 8'd0;
                48: bus.div_val = 8'd3;
                53: bus.run_sw = 1'b0;
                55: checkOutput("run_state_before_halt", 32'(bus.state), 1);
                56: begin
                    checkOutput("run_state_halted", 32'(bus.state), 0);
                    checkOutput("run_cnt_wrapped", 32'(bus.cycle_cnt), 0);
                    checkOutput("run_phase", 32'(bus.cpu_phase), 0);
                end
                default: ;
            endcase
        end

        // Reset asserted mid-period aborts; nothing follows its release.
        c = cyc;
        applyStimulus(1'b1, 1'b0, 8'd3);
        expectPulse(c + 7);
        waitCycles(9);
        rst_n = 1'b0;
        bus.run_sw = 1'b0;
        #1;
        checkOutput("midrun_reset_ce", 32'(bus.cpu_ce), 0);
        checkOutput("midrun_reset_cnt", 32'(bus.cycle_cnt), 0);
        checkOutput("midrun_reset_state", 32'(bus.state), 0);
        pulse_n = 0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("post_reset_state", 32'(bus.state), 0);
        checkOutput("post_reset_cnt", 32'(bus.cycle_cnt), 0);

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        // Breakpoint suppresses the first due pulse; a step then moves off it.
        c = cyc;
        bus.bp_addr  = 32'h40;
        bus.cpu_pc   = 32'h40;
        bus.bp_valid = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd3);
        expectPulse(c + 21);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            case (k)
                5: bus.run_sw = 1'b0;
                8: begin
                    checkOutput("bp_state", 32'(bus.state), 0);
                    checkOutput("bp_hit_set", 32'(bus.bp_hit), 1);
                end
                12: bus.step_btn = 1'b1;
                21: checkOutput("bp_hit_cleared", 32'(bus.bp_hit), 0);
                30: bus.step_btn = 1'b0;
                default: ;
            endcase
        end
`endif

        checkOutput("pending_ce", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
